ahb_mst_req_gen: RTL and testbench

Parametrised, synthesisable request generator for the multi-master AHB subsystem. It replaces hand-written initial-block stimulus that drives each AHB_MASTER's mst_wr_req / mst_rd_req / src_addr / block_size. It supports NUM_MST channels, each with a staggered start, a programmable request count and per-request address stepping, and it handshakes every request against an acknowledge from the bus side. Each channel reports completion and timeout.

---
 rtl/ahb_mst_req_gen.sv | 190 +++++++++++++++++++
 tb/tb_ahb_mst_req_gen.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ahb_mst_req_gen.sv
// Multi-channel AHB master request generator: staggered starts, request/ack handshake, timeout.
// Build macro ALT_RW_EN: alternate write/read per handshake, address advancing once per pair.
module ahb_mst_req_gen #(
  parameter int NUM_MST     = 4,
  parameter int ADDR_W      = 32,
  parameter int NUM_REQ     = 4,
  parameter int ADDR_STRIDE = 16,
  parameter int STAGGER     = 8,
  parameter int GAP         = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic                      hclk,
  input  logic                      hresetn,
  input  logic                      start,
  input  logic                      abort,
  input  logic [NUM_MST*ADDR_W-1:0] base_addr,
  input  logic [2:0]                blk_size,
  input  logic [NUM_MST-1:0]        wr_mode,
  input  logic [NUM_MST-1:0]        req_ack,
  output logic [NUM_MST-1:0]        mst_wr_req,
  output logic [NUM_MST-1:0]        mst_rd_req,
  output logic [NUM_MST*ADDR_W-1:0] src_addr,
  output logic [NUM_MST*3-1:0]      block_size,
  output logic [NUM_MST-1:0]        chan_done,
  output logic [NUM_MST-1:0]        timeout_err,
  output logic                      busy,
  output logic                      all_done
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DLY  = 3'd1,
    ST_REQ  = 3'd2,
    ST_GAP  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam int MAX_DLY = (NUM_MST - 1) * STAGGER;
  localparam int DLY_W   = (MAX_DLY < 2) ? 1 : $clog2(MAX_DLY + 1);
  localparam int GAP_W   = (GAP < 2) ? 1 : $clog2(GAP + 1);
  localparam int TO_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam int CNT_W   = $clog2(NUM_REQ + 1);

  logic [NUM_MST-1:0] chan_busy_s;
  logic               start_ok_s;

  assign busy       = |chan_busy_s;
  assign start_ok_s = start & ~abort & ~busy;
  assign all_done   = &chan_done;

  genvar i;
  generate
    for (i = 0; i < NUM_MST; i++) begin : g_chan
      localparam logic [DLY_W-1:0] DLY_INIT = DLY_W'(i * STAGGER);

      state_t            state_r;
      logic [DLY_W-1:0]  dly_cnt_r;
      logic [GAP_W-1:0]  gap_cnt_r;
      logic [TO_W-1:0]   wait_cnt_r;
      logic [CNT_W-1:0]  req_cnt_r;
      logic [ADDR_W-1:0] addr_r;
      logic [2:0]        bsize_r;
      logic              wr_mode_r;
      logic              wr_req_r;
      logic              rd_req_r;
      logic              done_r;
      logic              to_err_r;
      logic              dir_s;
      logic              adv_s;
      logic              last_s;

`ifdef ALT_RW_EN
      logic phase_r;
      assign dir_s = wr_mode_r ^ phase_r;
      // A pair completes on its second handshake; only then does the address move on
      assign adv_s = phase_r;
`else
      assign dir_s = wr_mode_r;
      assign adv_s = 1'b1;
`endif
      assign last_s = (req_cnt_r == CNT_W'(NUM_REQ - 1));

      assign chan_busy_s[i]               = (state_r != ST_IDLE) && (state_r != ST_DONE);
      assign mst_wr_req[i]                = wr_req_r;
      assign mst_rd_req[i]                = rd_req_r;
      assign src_addr[i*ADDR_W +: ADDR_W] = addr_r;
      assign block_size[i*3 +: 3]         = bsize_r;
      assign chan_done[i]                 = done_r;
      assign timeout_err[i]               = to_err_r;

      // Channel FSM with registered request, address and status outputs
      always_ff @(posedge hclk) begin
        if (!hresetn) begin
          state_r    <= ST_IDLE;
          dly_cnt_r  <= '0;
          gap_cnt_r  <= '0;
          wait_cnt_r <= '0;
          req_cnt_r  <= '0;
          addr_r     <= '0;
          bsize_r    <= 3'b000;
          wr_mode_r  <= 1'b0;
          wr_req_r   <= 1'b0;
          rd_req_r   <= 1'b0;
          done_r     <= 1'b0;
          to_err_r   <= 1'b0;
`ifdef ALT_RW_EN
          phase_r    <= 1'b0;
`endif
        end else if (abort) begin
          state_r  <= ST_IDLE;
          wr_req_r <= 1'b0;
          rd_req_r <= 1'b0;
        end else begin
          case (state_r)
            ST_IDLE, ST_DONE: begin
              if (start_ok_s) begin
                state_r   <= ST_DLY;
                dly_cnt_r <= DLY_INIT;
                addr_r    <= base_addr[i*ADDR_W +: ADDR_W];
                bsize_r   <= blk_size;
                wr_mode_r <= wr_mode[i];
                req_cnt_r <= '0;
                done_r    <= 1'b0;
                to_err_r  <= 1'b0;
`ifdef ALT_RW_EN
                phase_r   <= 1'b0;
`endif
              end
            end
            ST_DLY: begin
              if (dly_cnt_r == DLY_W'(0)) begin
                state_r    <= ST_REQ;
                wait_cnt_r <= '0;
                wr_req_r   <= dir_s;
                rd_req_r   <= ~dir_s;
              end else begin
                dly_cnt_r <= dly_cnt_r - DLY_W'(1);
              end
            end
            ST_REQ: begin
              if (req_ack[i]) begin
                wr_req_r <= 1'b0;
                rd_req_r <= 1'b0;
`ifdef ALT_RW_EN
                phase_r  <= ~phase_r;
`endif
                if (adv_s) begin
                  addr_r    <= addr_r + ADDR_W'(ADDR_STRIDE);
                  req_cnt_r <= req_cnt_r + CNT_W'(1);
                end
                if (adv_s && last_s) begin
                  state_r <= ST_DONE;
                  done_r  <= 1'b1;
                end else begin
                  state_r   <= ST_GAP;
                  gap_cnt_r <= GAP_W'(GAP);
                end
              end else if (wait_cnt_r == TO_W'(TIMEOUT - 1)) begin
                wr_req_r <= 1'b0;
                rd_req_r <= 1'b0;
                to_err_r <= 1'b1;
                done_r   <= 1'b1;
                state_r  <= ST_DONE;
              end else begin
                wait_cnt_r <= wait_cnt_r + TO_W'(1);
              end
            end
            ST_GAP: begin
              // GAP state always lasts at least one cycle so each request shows a fresh rising edge
              if (gap_cnt_r == GAP_W'(0)) begin
                state_r    <= ST_REQ;
                wait_cnt_r <= '0;
                wr_req_r   <= dir_s;
                rd_req_r   <= ~dir_s;
              end else begin
                gap_cnt_r <= gap_cnt_r - GAP_W'(1);
              end
            end
            default: begin
              state_r  <= ST_IDLE;
              wr_req_r <= 1'b0;
              rd_req_r <= 1'b0;
            end
          endcase
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_ahb_mst_req_gen.sv
// Bench for ahb_mst_req_gen: table-driven runs and random runs checked cycle by cycle
// against a timeline model, plus hand sequences for reset and abort.
module tb_ahb_mst_req_gen;
  localparam int NM = 4, AW = 32, NR = 4, STRIDE = 16, STAG = 8, GP = 4, TO = 255;
  localparam int BIG = 32'h3FFF_FFFF;
`ifdef ALT_RW_EN
  localparam int HS = 2 * NR;
  localparam bit ALT = 1'b1;
`else
  localparam int HS = NR;
  localparam bit ALT = 1'b0;
`endif

  typedef struct {
    logic [AW-1:0] base0;
    logic [NM-1:0] wm;
    logic [2:0]    blk;
    int            dly;
    int            to_ch;
    logic [AW-1:0] exp_addr0;
    logic [NM-1:0] exp_err;
  } vec_t;

  logic            hclk = 1'b0;
  logic            hresetn, start, abort;
  logic [NM*AW-1:0] base_addr;
  logic [2:0]      blk_size;
  logic [NM-1:0]   wr_mode, req_ack;
  logic [NM-1:0]   mst_wr_req, mst_rd_req, chan_done, timeout_err;
  logic [NM*AW-1:0] src_addr;
  logic [NM*3-1:0] block_size;
  logic            busy, all_done;

  int cyc = 0;
  int n_pass = 0;
  int n_tot = 0;

  int            r_t[NM][HS];
  int            a_t[NM][HS];
  int            done_t[NM];
  logic [AW-1:0] m_base[NM];
  logic [NM-1:0] m_wr;
  logic [2:0]    m_blk;
  int            m_to;
  vec_t          vecs[3];

  ahb_mst_req_gen #(.NUM_MST(NM), .ADDR_W(AW), .NUM_REQ(NR), .ADDR_STRIDE(STRIDE),
                    .STAGGER(STAG), .GAP(GP), .TIMEOUT(TO)) dut (
    .hclk(hclk), .hresetn(hresetn), .start(start), .abort(abort),
    .base_addr(base_addr), .blk_size(blk_size), .wr_mode(wr_mode), .req_ack(req_ack),
    .mst_wr_req(mst_wr_req), .mst_rd_req(mst_rd_req), .src_addr(src_addr),
    .block_size(block_size), .chan_done(chan_done), .timeout_err(timeout_err),
    .busy(busy), .all_done(all_done)
  );

  always #5 hclk = ~hclk;
  always @(posedge hclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Index of the handshake whose request is visible after edge t, or -1
  function automatic int active_k(int i, int t);
    for (int k = 0; k < HS; k++)
      if (r_t[i][k] <= t && t < a_t[i][k]) return k;
    return -1;
  endfunction

  function automatic int acks_done(int i, int t);
    int n = 0;
    if (i == m_to) return 0;
    for (int k = 0; k < HS; k++)
      if (a_t[i][k] <= t) n++;
    return n;
  endfunction

  // Timeline: first rise at s+1+i*STAG, ack d cycles after rise, next rise GAP+1 after ack
  task automatic plan(input int s, input int dmode);
    for (int i = 0; i < NM; i++) begin
      int t0;
      t0 = s + 1 + i * STAG;
      for (int k = 0; k < HS; k++) begin
        int d;
        d = (dmode < 0) ? int'($urandom_range(0, 4)) : dmode;
        if (i == m_to) begin
          r_t[i][k] = (k == 0) ? t0 : BIG;
          a_t[i][k] = (k == 0) ? t0 + TO : BIG;
        end else begin
          r_t[i][k] = t0;
          a_t[i][k] = t0 + 1 + d;
          t0 = a_t[i][k] + GP + 1;
        end
      end
      done_t[i] = (i == m_to) ? r_t[i][0] + TO : a_t[i][HS-1];
    end
  endtask

  task automatic run(input logic [AW-1:0] b0, input logic [NM-1:0] wm, input logic [2:0] blk,
                     input int dmode, input int to_ch, input bit rnd);
    int s, t_end, t, k, n;
    bit dir, eb, ea;
    logic [NM-1:0] ack_v;
    logic [63:0] exp_v, act_v;
    for (int i = 0; i < NM; i++) begin
      m_base[i] = (i == 0) ? b0 : (rnd ? AW'($urandom) : b0 + AW'(i * 256));
      base_addr[i*AW +: AW] = m_base[i];
    end
    m_wr = wm; m_blk = blk; m_to = to_ch;
    wr_mode = wm; blk_size = blk; start = 1'b1;
    s = cyc + 1;
    plan(s, dmode);
    t_end = 0;
    for (int i = 0; i < NM; i++) if (done_t[i] > t_end) t_end = done_t[i];
    t_end += 2;
    @(negedge hclk);
    while (cyc <= t_end) begin
      t = cyc;
      start = (t == s + 3);
      if (t == s + 3) begin
        base_addr = {$urandom, $urandom, $urandom, $urandom};
        wr_mode = ~wm;
      end
      eb = 1'b0; ea = 1'b1;
      for (int i = 0; i < NM; i++) begin
        k = active_k(i, t);
        n = acks_done(i, t);
        dir = m_wr[i] ^ (ALT && (k % 2 == 1));
        exp_v = {25'd0, (k >= 0) && dir, (k >= 0) && !dir,
                 m_base[i] + AW'(STRIDE * (ALT ? n / 2 : n)), m_blk,
                 t >= done_t[i], (i == m_to) && (t >= done_t[i])};
        act_v = {25'd0, mst_wr_req[i], mst_rd_req[i], src_addr[i*AW +: AW],
                 block_size[i*3 +: 3], chan_done[i], timeout_err[i]};
        check($sformatf("chan%0d_t%0d", i, t - s), act_v, exp_v);
        if (t < done_t[i]) eb = 1'b1; else ea = ea;
        if (t < done_t[i]) ea = 1'b0;
        ack_v[i] = 1'b0;
        if (i != m_to)
          for (int j = 0; j < HS; j++) if (a_t[i][j] == t + 1) ack_v[i] = 1'b1;
        if (!ack_v[i] && k < 0 && $urandom_range(0, 3) == 0) ack_v[i] = 1'b1;
      end
      check($sformatf("busy_alldone_t%0d", t - s), 64'({busy, all_done}), 64'({eb, ea}));
      req_ack = ack_v;
      @(negedge hclk);
    end
    req_ack = '0;
    start = 1'b0;
  endtask

  initial begin
    vecs[0] = '{32'h0000_0000, 4'b1111, 3'b011, 2, -1, 32'h0000_0040, 4'b0000};
    vecs[1] = '{32'hFFFF_FFF0, 4'b0101, 3'b101, 0, -1, 32'h0000_0030, 4'b0000};
    vecs[2] = '{32'h0000_1000, 4'b0000, 3'b111, 1,  2, 32'h0000_1040, 4'b0100};

    hresetn = 1'b0; start = 1'b1; abort = 1'b0; req_ack = '0;
    base_addr = '0; blk_size = 3'b000; wr_mode = '0;
    repeat (2) @(negedge hclk);
    check("reset_ctrl", 64'({mst_wr_req, mst_rd_req, chan_done, timeout_err, busy, all_done}), 64'd0);
    check("reset_addr_bsz", 64'({|src_addr, |block_size}), 64'd0);
    hresetn = 1'b1; start = 1'b0;
    @(negedge hclk);

    for (int v = 0; v < 3; v++) begin
      run(vecs[v].base0, vecs[v].wm, vecs[v].blk, vecs[v].dly, vecs[v].to_ch, 1'b0);
      check($sformatf("final_addr0_v%0d", v), 64'(src_addr[AW-1:0]), 64'(vecs[v].exp_addr0));
      check($sformatf("final_err_v%0d", v), 64'(timeout_err), 64'(vecs[v].exp_err));
    end

    for (int r = 0; r < 4; r++)
      run(AW'($urandom), NM'($urandom), 3'($urandom), -1,
          ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1, 1'b1);

    // start together with abort is ignored; abort leaves chan_done alone
    start = 1'b1; abort = 1'b1;
    @(negedge hclk);
    start = 1'b0; abort = 1'b0;
    check("start_with_abort", 64'({busy, chan_done}), 64'({1'b0, 4'hF}));
    abort = 1'b1;
    @(negedge hclk);
    abort = 1'b0;
    check("abort_in_done", 64'(chan_done), 64'hF);

    base_addr = {4{32'h0000_2000}}; wr_mode = 4'b1111; blk_size = 3'b010; start = 1'b1;
    @(negedge hclk);
    start = 1'b0;
    check("restart_clears_done", 64'({busy, chan_done}), 64'({1'b1, 4'h0}));
    @(negedge hclk);
    check("req_before_abort", 64'({mst_wr_req[0], mst_rd_req[0]}), 64'(2'b10));
    abort = 1'b1; req_ack = 4'b0001;
    @(negedge hclk);
    abort = 1'b0; req_ack = '0;
    check("abort_drops_req", 64'({mst_wr_req, mst_rd_req, busy}), 64'd0);
    check("abort_no_advance", 64'(src_addr[AW-1:0]), 64'h2000);
    check("abort_keeps_done", 64'(chan_done), 64'd0);

    start = 1'b1;
    @(negedge hclk);
    start = 1'b0;
    @(negedge hclk);
    check("req_before_reset", 64'(mst_wr_req[0]), 64'd1);
    hresetn = 1'b0;
    @(negedge hclk);
    hresetn = 1'b1;
    check("reset_mid_req", 64'({mst_wr_req, mst_rd_req, busy, chan_done, timeout_err, block_size}), 64'd0);
    check("reset_mid_addr", 64'(|src_addr), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
